// File: rtl/nvdla_dma_pkg.sv
// Shared DMA read-interface widths, payload layouts and responder FSM states.
// Request pd:  [63:0] byte address, [78:64] size (beats - 1).
// Response pd: [255:0] data, [256] mask.
package nvdla_dma_pkg;

  localparam int unsigned DMA_AW     = 64;
  localparam int unsigned DMA_SIZE_W = 15;
  localparam int unsigned DMA_DW     = 256;
  localparam int unsigned DMA_MASK_W = 1;

  localparam int unsigned RD_REQ_PW = 79;
  localparam int unsigned RD_RSP_PW = 257;

  // Request / response field offsets.
  localparam int unsigned RD_REQ_ADDR_LSB = 0;
  localparam int unsigned RD_REQ_SIZE_LSB = DMA_AW;
  localparam int unsigned RD_RSP_DATA_LSB = 0;
  localparam int unsigned RD_RSP_MASK_LSB = DMA_DW;

  // Atoms are 32 bytes, so the atom index starts at address bit 5.
  localparam int unsigned ATOM_LSB = 5;

  typedef struct packed {
    logic [DMA_MASK_W-1:0] mask;
    logic [DMA_DW-1:0]     data;
  } rd_rsp_pd_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } rd_state_e;

endpackage

// File: rtl/nvdla_rd_rsp_fifo2.sv
// Two-entry registered response FIFO, no bypass. Entry 0 is always the head,
// so the read data comes straight from a flop.
// Ports: clk, rst (async high), push/wdata, pop, valid/rdata (head), cnt.
module nvdla_rd_rsp_fifo2
  import nvdla_dma_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [RD_RSP_PW-1:0] wdata,
  input  logic                 pop,
  output logic                 valid,
  output logic [RD_RSP_PW-1:0] rdata,
  output logic [1:0]           cnt
);

  logic [RD_RSP_PW-1:0] ent0;
  logic [RD_RSP_PW-1:0] ent1;
  logic [1:0]           cnt_q;

  // Shift-down storage; a push lands in the first free slot after any pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0  <= '0;
      ent1  <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0 <= wdata;
          else               ent1 <= wdata;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            ent0 <= ent1;
            ent1 <= wdata;
          end else begin
            ent0 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign rdata = ent0;
  assign cnt   = cnt_q;

endmodule

// File: rtl/nvdla_mcif_rd_responder.sv
// Memory-side read responder for the SDP DMA read channel. Splits each request
// into 256-bit atom reads on a 1-cycle SRAM port and returns the data, in order,
// as response beats while respecting the client's latency-FIFO credits.
// Ports:
//   nvdla_core_clk / nvdla_core_rst  clock, async active-high reset
//   sdp2mcif_rd_req_*                request (valid/ready/pd)
//   mcif2sdp_rd_rsp_*                response beats (valid/ready/pd)
//   sdp2mcif_rd_cdt_lat_fifo_pop     one credit returned per pulse
//   mem_rd_en/addr/data              SRAM read port
//   credit_err                       sticky credit overflow flag
//   idle                             nothing active, in flight or buffered
module nvdla_mcif_rd_responder
  import nvdla_dma_pkg::*;
#(
  parameter int unsigned LAT_FIFO_DEPTH = 8,
  parameter int unsigned MEM_AW         = 16
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic                 sdp2mcif_rd_req_valid,
  output logic                 sdp2mcif_rd_req_ready,
  input  logic [RD_REQ_PW-1:0] sdp2mcif_rd_req_pd,
  output logic                 mcif2sdp_rd_rsp_valid,
  input  logic                 mcif2sdp_rd_rsp_ready,
  output logic [RD_RSP_PW-1:0] mcif2sdp_rd_rsp_pd,
  input  logic                 sdp2mcif_rd_cdt_lat_fifo_pop,
  output logic                 mem_rd_en,
  output logic [MEM_AW-1:0]    mem_rd_addr,
  input  logic [DMA_DW-1:0]    mem_rd_data,
  output logic                 credit_err,
  output logic                 idle
);

  localparam int unsigned    CW         = $clog2(LAT_FIFO_DEPTH + 1);
  localparam logic [CW-1:0]  CREDIT_MAX = CW'(LAT_FIFO_DEPTH);

  rd_state_e             state, state_nxt;
  logic [MEM_AW-1:0]     atom_addr, atom_addr_nxt;
  logic [DMA_SIZE_W-1:0] remain, remain_nxt;
  logic [CW-1:0]         credit, credit_nxt;
  logic                  credit_err_nxt;
  logic                  inflight;
  logic [1:0]            fifo_cnt;
  logic [2:0]            occ;
  logic                  req_acc;
  logic                  rsp_pop;
  logic                  cdt_pop;
  logic                  issue;
  rd_rsp_pd_t            rsp_wdata;
  logic                  unused_req_bits;

  // Byte offset within the atom and address bits above the SRAM are ignored.
  assign unused_req_bits = ^{sdp2mcif_rd_req_pd[ATOM_LSB-1:RD_REQ_ADDR_LSB],
                             sdp2mcif_rd_req_pd[DMA_AW-1:ATOM_LSB+MEM_AW]};

  assign sdp2mcif_rd_req_ready = (state == ST_IDLE);
  assign req_acc = sdp2mcif_rd_req_valid & sdp2mcif_rd_req_ready;
  assign rsp_pop = mcif2sdp_rd_rsp_valid & mcif2sdp_rd_rsp_ready;
  assign cdt_pop = sdp2mcif_rd_cdt_lat_fifo_pop;

  // Projected FIFO occupancy once the in-flight beat lands; a new read may only
  // issue if its data is guaranteed a slot.
  assign occ   = 3'(fifo_cnt) + 3'(inflight) - 3'(rsp_pop);
  assign issue = (state == ST_ISSUE) && (credit != '0) && (occ < 3'd2);

  assign mem_rd_en   = issue;
  assign mem_rd_addr = atom_addr;

  // Next-state: request load, per-issue address/remain stepping, credit ledger.
  always_comb begin
    state_nxt      = state;
    atom_addr_nxt  = atom_addr;
    remain_nxt     = remain;
    credit_nxt     = credit;
    credit_err_nxt = credit_err;
    case (state)
      ST_IDLE: begin
        if (req_acc) begin
          atom_addr_nxt = sdp2mcif_rd_req_pd[ATOM_LSB +: MEM_AW];
          remain_nxt    = sdp2mcif_rd_req_pd[RD_REQ_SIZE_LSB +: DMA_SIZE_W];
          state_nxt     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          atom_addr_nxt = atom_addr + MEM_AW'(1);
          remain_nxt    = remain - DMA_SIZE_W'(1);
          if (remain == '0) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (issue && !cdt_pop) begin
      credit_nxt = credit - CW'(1);
    end else if (cdt_pop && !issue) begin
      if (credit == CREDIT_MAX) credit_err_nxt = 1'b1;
      else                      credit_nxt     = credit + CW'(1);
    end
  end

  // State register.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state      <= ST_IDLE;
      atom_addr  <= '0;
      remain     <= '0;
      credit     <= CREDIT_MAX;
      credit_err <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      state      <= state_nxt;
      atom_addr  <= atom_addr_nxt;
      remain     <= remain_nxt;
      credit     <= credit_nxt;
      credit_err <= credit_err_nxt;
      inflight   <= issue;
    end
  end

  assign rsp_wdata.mask = DMA_MASK_W'(1);
  assign rsp_wdata.data = mem_rd_data;

  nvdla_rd_rsp_fifo2 u_rsp_fifo (
    .clk   (nvdla_core_clk),
    .rst   (nvdla_core_rst),
    .push  (inflight),
    .wdata (rsp_wdata),
    .pop   (rsp_pop),
    .valid (mcif2sdp_rd_rsp_valid),
    .rdata (mcif2sdp_rd_rsp_pd),
    .cnt   (fifo_cnt)
  );

  assign idle = (state == ST_IDLE) && !inflight && (fifo_cnt == 2'd0);

endmodule

// File: tb/tb_nvdla_mcif_rd_responder.sv
// Directed bench for nvdla_mcif_rd_responder: single beat, burst, credit stall,
// random backpressure, address wrap, credit error and reset mid-burst.
module tb_nvdla_mcif_rd_responder;
  import nvdla_dma_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid;
  logic         req_ready;
  logic [78:0]  req_pd;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [256:0] rsp_pd;
  logic         pop;
  logic         pop_man;
  logic         pop_pend;
  logic         auto_pop;
  logic         mem_rd_en;
  logic [15:0]  mem_rd_addr;
  logic [255:0] mem_rd_data;
  logic         credit_err;
  logic         idle;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0]  iss_addr[$];
  int           iss_cyc[$];
  logic [256:0] rx[$];

  always #5 clk = ~clk;

  nvdla_mcif_rd_responder #(.LAT_FIFO_DEPTH(8), .MEM_AW(16)) dut (
    .nvdla_core_clk               (clk),
    .nvdla_core_rst               (rst),
    .sdp2mcif_rd_req_valid        (req_valid),
    .sdp2mcif_rd_req_ready        (req_ready),
    .sdp2mcif_rd_req_pd           (req_pd),
    .mcif2sdp_rd_rsp_valid        (rsp_valid),
    .mcif2sdp_rd_rsp_ready        (rsp_ready),
    .mcif2sdp_rd_rsp_pd           (rsp_pd),
    .sdp2mcif_rd_cdt_lat_fifo_pop (pop),
    .mem_rd_en                    (mem_rd_en),
    .mem_rd_addr                  (mem_rd_addr),
    .mem_rd_data                  (mem_rd_data),
    .credit_err                   (credit_err),
    .idle                         (idle)
  );

  // SRAM content: atom 2 holds all 0xA5, every other atom a pattern of its index.
  function automatic logic [255:0] pat(input logic [15:0] a);
    if (a == 16'd2) return {32{8'hA5}};
    return {8{~a, a}};
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= pat(mem_rd_addr);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst) begin
      if (mem_rd_en) begin
        iss_addr.push_back(mem_rd_addr);
        iss_cyc.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) rx.push_back(rsp_pd);
    end
  end

  // Client model: each accepted beat leaves the latency FIFO one cycle later.
  always @(posedge clk or posedge rst) begin
    if (rst) pop_pend <= 1'b0;
    else     pop_pend <= auto_pop && rsp_valid && rsp_ready;
  end
  assign pop = pop_pend | pop_man;

  task automatic check(input string tag, input logic [256:0] act, input logic [256:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_addr.delete();
    iss_cyc.delete();
    rx.delete();
  endtask

  // Presents one request; returns in the cycle after the accepting edge.
  task automatic send_req(input logic [63:0] a, input logic [14:0] s);
    int w = 0;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    check("req_ready_wait", 257'(req_ready), 257'(1));
    req_pd    = {s, a};
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_pd    = '0;
  endtask

  task automatic wait_rx(input int n, input string tag);
    int w = 0;
    while (rx.size() < n && w < 400) begin
      tick();
      w++;
    end
    check(tag, 257'(rx.size()), 257'(n));
  endtask

  task automatic wait_idle(input string tag);
    int w = 0;
    while (!idle && w < 400) begin
      tick();
      w++;
    end
    repeat (3) tick();
    check(tag, 257'(idle), 257'(1));
  endtask

  task automatic check_rx(input logic [15:0] base, input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= rx.size()) bad++;
      else if (rx[i] !== {1'b1, pat(16'(base + 16'(i)))}) bad++;
    end
    check(tag, 257'(bad), 257'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  257'(req_ready),  257'(1));
    check({tag, "_rsp_valid"},  257'(rsp_valid),  257'(0));
    check({tag, "_rsp_pd"},     rsp_pd,           257'(0));
    check({tag, "_mem_rd_en"},  257'(mem_rd_en),  257'(0));
    check({tag, "_mem_addr"},   257'(mem_rd_addr), 257'(0));
    check({tag, "_credit"},     257'(dut.credit), 257'(8));
    check({tag, "_credit_err"}, 257'(credit_err), 257'(0));
    check({tag, "_idle"},       257'(idle),       257'(1));
  endtask

  initial begin
    int bad;
    logic [256:0] a5_beat;
    req_valid = 1'b0;
    req_pd    = '0;
    rsp_ready = 1'b0;
    pop_man   = 1'b0;
    auto_pop  = 1'b0;
    a5_beat   = {1'b1, {32{8'hA5}}};

    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();

    // Single beat, cycle-exact latency
    rsp_ready = 1'b1;
    auto_pop  = 1'b1;
    clear_logs();
    req_pd    = {15'd0, 64'h40};
    req_valid = 1'b1;
    check("t1_req_ready_c0", 257'(req_ready), 257'(1));
    tick();
    req_valid = 1'b0;
    req_pd    = '0;
    check("t1_mem_en_c1", 257'(mem_rd_en), 257'(1));
    check("t1_mem_addr_c1", 257'(mem_rd_addr), 257'(2));
    check("t1_req_ready_c1", 257'(req_ready), 257'(0));
    tick();
    check("t1_mem_en_c2", 257'(mem_rd_en), 257'(0));
    check("t1_req_ready_c2", 257'(req_ready), 257'(1));
    check("t1_rsp_valid_c2", 257'(rsp_valid), 257'(0));
    check("t1_credit_c2", 257'(dut.credit), 257'(7));
    tick();
    check("t1_rsp_valid_c3", 257'(rsp_valid), 257'(1));
    check("t1_rsp_pd_c3", rsp_pd, a5_beat);
    tick();
    check("t1_rsp_valid_c4", 257'(rsp_valid), 257'(0));
    check("t1_idle_c4", 257'(idle), 257'(1));
    tick();
    check("t1_credit_c5", 257'(dut.credit), 257'(8));

    // 16-beat burst at full rate
    clear_logs();
    send_req(64'h1000, 15'd15);
    wait_rx(16, "t2_rx_count");
    check("t2_issue_count", 257'(iss_addr.size()), 257'(16));
    bad = 0;
    for (int i = 0; i < iss_addr.size(); i++) begin
      if (iss_addr[i] !== 16'(16'h80 + 16'(i))) bad++;
      if (iss_cyc[i] != iss_cyc[0] + i) bad++;
    end
    check("t2_issue_addr_cycle", 257'(bad), 257'(0));
    check_rx(16'h80, 16, "t2_rx_data");
    wait_idle("t2_idle");
    check("t2_credit_end", 257'(dut.credit), 257'(8));

    // Credit stall: 8 issues, then one pop releases exactly one more
    auto_pop = 1'b0;
    clear_logs();
    send_req(64'h0, 15'd11);
    repeat (20) tick();
    check("t3_issue_stall", 257'(iss_addr.size()), 257'(8));
    check("t3_mem_en_stall", 257'(mem_rd_en), 257'(0));
    check("t3_credit_zero", 257'(dut.credit), 257'(0));
    pop_man = 1'b1;
    tick();
    pop_man = 1'b0;
    check("t3_resume_en", 257'(mem_rd_en), 257'(1));
    check("t3_resume_addr", 257'(mem_rd_addr), 257'(8));
    tick();
    check("t3_one_only", 257'(mem_rd_en), 257'(0));
    check("t3_issue_9", 257'(iss_addr.size()), 257'(9));
    pop_man = 1'b1;
    repeat (11) tick();
    pop_man = 1'b0;
    wait_rx(12, "t3_rx_count");
    check_rx(16'h0, 12, "t3_rx_data");
    wait_idle("t3_idle");
    check("t3_credit_end", 257'(dut.credit), 257'(8));
    check("t3_no_err", 257'(credit_err), 257'(0));

    // Random response backpressure
    auto_pop = 1'b1;
    clear_logs();
    send_req(64'h2000, 15'd31);
    for (int i = 0; i < 600 && rx.size() < 32; i++) begin
      logic         stalled;
      logic [256:0] held;
      rsp_ready = 1'($urandom_range(0, 1));
      stalled   = rsp_valid && !rsp_ready;
      held      = rsp_pd;
      tick();
      if (stalled) begin
        check("t4_valid_hold", 257'(rsp_valid), 257'(1));
        check("t4_pd_hold", rsp_pd, held);
      end
    end
    rsp_ready = 1'b1;
    wait_rx(32, "t4_rx_count");
    wait_idle("t4_idle");
    check("t4_rx_exact", 257'(rx.size()), 257'(32));
    check_rx(16'h100, 32, "t4_rx_data");
    check("t4_credit_end", 257'(dut.credit), 257'(8));

    // Address wrap, then a pop at full credit
    clear_logs();
    send_req(64'h1F_FFE0, 15'd1);
    wait_rx(2, "t5_rx_count");
    check("t5_issue_count", 257'(iss_addr.size()), 257'(2));
    if (iss_addr.size() >= 2) begin
      check("t5_addr0", 257'(iss_addr[0]), 257'(16'hFFFF));
      check("t5_addr1", 257'(iss_addr[1]), 257'(16'h0000));
    end
    check_rx(16'hFFFF, 2, "t5_rx_data");
    wait_idle("t5_idle");
    check("t5_err_before", 257'(credit_err), 257'(0));
    pop_man = 1'b1;
    tick();
    pop_man = 1'b0;
    tick();
    check("t5_credit_err", 257'(credit_err), 257'(1));
    check("t5_credit_sat", 257'(dut.credit), 257'(8));

    // Asynchronous reset in the middle of a burst
    clear_logs();
    send_req(64'h1000, 15'd15);
    for (int i = 0; i < 50 && iss_addr.size() < 5; i++) tick();
    check("t6_reached_beat5", 257'(iss_addr.size() >= 5), 257'(1));
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
    clear_logs();
    send_req(64'h40, 15'd3);
    wait_rx(4, "t6_rx_count");
    check("t6_issue_count", 257'(iss_addr.size()), 257'(4));
    check_rx(16'h2, 4, "t6_rx_data");
    wait_idle("t6_idle");
    check("t6_credit_end", 257'(dut.credit), 257'(8));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
